mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between instruction fetch and the memory stage.
- Sequences each access as arbitrate -> issue -> wait-for-done, then returns completion and read data to the winning requester.
- Data accesses have priority over fetch; a bounded-streak rule prevents fetch starvation.
- Sits between fetch/memory stages and the shared memory model.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch waits; 0 = strict data priority, no starvation guard

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  ADDR_W  fetch address
- if_done  out  1  one-cycle completion pulse to fetch
- if_rdata  out  DATA_W  instruction; valid only with if_done
- d_rd  in  1  data read request; held until d_done
- d_wr  in  1  data write request; held until d_done
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_done  out  1  one-cycle completion pulse to memory stage
- d_rdata  out  DATA_W  load data; valid only with d_done
- mem_rd  out  1  memory read strobe, one cycle per access
- mem_wr  out  1  memory write strobe, one cycle per access
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_done  in  1  memory completion; earliest one cycle after the strobe
- mem_rdata  in  DATA_W  memory read data; valid with mem_done

Behaviour:
- Reset values:
  - state=IDLE, all strobes and dones 0, mem_addr/mem_wdata 0, streak counter 0.
  - Reset mid-access abandons it; no done pulse is produced.
- FSM states:
  - IDLE: arbitrate. If any request is present, latch owner, addr and wdata, then go to ISSUE. Otherwise stay.
  - ISSUE: drive mem_rd or mem_wr from registers for exactly one cycle, then go to WAIT.
  - WAIT: hold mem_addr/mem_wdata. On mem_done, pulse the owner's done combinationally with data = mem_rdata, then go to IDLE.
- Arbitration in IDLE:
  - d_rd|d_wr wins unless if_req is present and streak == MAX_DATA_STREAK (with MAX_DATA_STREAK > 0).
  - Fetch is always a read.
  - d_rd & d_wr together: treated as a write.
- Streak counter:
  - Increments when data wins while if_req is high.
  - Clears on a fetch grant, and on a data grant with if_req low.
  - Saturates at MAX_DATA_STREAK.
- Latency: request in cycle N -> strobe in N+1 -> done in the same cycle as mem_done (earliest N+2).
- Spacing: one IDLE bubble between accesses, so the minimum is 3 cycles per access.
- Requesters must drop the request the cycle after done. A request still high in the done cycle is not double-counted because arbitration happens only in IDLE, the cycle after done.
- Unused output data buses read 0.
- mem_done in IDLE or ISSUE is ignored: no done pulse, no state change.
- if_done and d_done are never high together.
- Latched addr/wdata are not affected by changes on the inputs after the grant.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds outputs stat_conflicts (16) and stat_if_wait (16), both free-running, wrap at 0xFFFF, cleared by rst.
  - stat_conflicts increments on each IDLE cycle where both a fetch and a data request are present.
  - stat_if_wait increments on each cycle where if_req=1 and if_done=0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package holds:
  - state encoding constants ARB_IDLE=2'd0, ARB_ISSUE=2'd1, ARB_WAIT=2'd2
  - owner encoding OWN_IF=1'b0, OWN_D=1'b1
- One natural sub-module, arb_streak_ctr: the streak counter plus the fetch-force decision.
- FSM and datapath registers stay in the top module.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0010, mem_done 2 cycles after mem_rd, mem_rdata=0xC0DE -> mem_rd high exactly 1 cycle with mem_addr=0x0010; if_done high 1 cycle with if_rdata=0xC0DE.
- Simultaneous requests: if_req and d_wr with d_addr=0x0200, d_wdata=0x1234 -> mem_wr issued first with 0x0200/0x1234, d_done first; fetch serviced after a one-cycle IDLE bubble.
- Starvation guard: MAX_DATA_STREAK=4, if_req and d_rd held continuously -> grant order D,D,D,D,IF,D,...
- Strict priority: MAX_DATA_STREAK=0 with the same stimulus -> no fetch grant while d_rd remains high.
- Reset in WAIT: assert rst for 1 cycle, then raise mem_done -> no done pulse, state IDLE, strobes 0; next request serviced normally.
- ARB_STATS_EN: 3 overlapping fetch/data pairs -> stat_conflicts=3; stat_if_wait equals the summed fetch wait cycles.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/data memory-port arbiter.
// Used by arb_streak_ctr and mem_port_arbiter.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  // Width of a counter that must hold 0..max_streak; never narrower than one bit.
  function automatic int streak_w(input int max_streak);
    return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_streak_ctr.sv
// Data-grant streak counter and fetch-force decision for mem_port_arbiter.
// A MAX_DATA_STREAK of 0 disables the guard and gives data strict priority.
module arb_streak_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_i,
  input  logic if_req_i,
  input  logic d_req_i,
  output logic force_if_o
);

  localparam int              CW         = streak_w(MAX_DATA_STREAK);
  localparam logic [CW-1:0]   STREAK_MAX = CW'(MAX_DATA_STREAK);

  logic [CW-1:0] streak_q, streak_d;

  assign force_if_o = (MAX_DATA_STREAK > 0) && if_req_i && (streak_q == STREAK_MAX);

  always_comb begin
    // NOTE: default first so every path assigns streak_d and no latch is inferred.
    streak_d = streak_q;
    if (arb_i) begin
      if (d_req_i && !force_if_o && if_req_i) begin
        if (streak_q != STREAK_MAX) streak_d = streak_q + CW'(1);
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all clocked state avoid ordering races.
    if (rst) streak_q <= '0;
    else     streak_q <= streak_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory between fetch and the data stage.
// Optional macro ARB_STATS_EN adds stat_conflicts and stat_if_wait counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stat_conflicts,
  output logic [15:0]       stat_if_wait
`endif
);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic d_req;
  logic arb_cycle;
  logic force_if;
  logic grant_d;
  logic done_hit;

  assign d_req     = d_rd | d_wr;
  assign arb_cycle = (state_q == ARB_IDLE) && (if_req || d_req);
  assign grant_d   = d_req && !force_if;

  arb_streak_ctr #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_streak (
    .clk       (clk),
    .rst       (rst),
    .arb_i     (arb_cycle),
    .if_req_i  (if_req),
    .d_req_i   (d_req),
    .force_if_o(force_if)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (arb_cycle) begin
          state_d = ARB_ISSUE;
          if (grant_d) begin
            // A simultaneous read and write request is served as a write.
            owner_d = OWN_D;
            wr_d    = d_wr;
            addr_d  = d_addr;
            wdata_d = d_wr ? d_wdata : '0;
          end else begin
            owner_d = OWN_IF;
            wr_d    = 1'b0;
            addr_d  = if_addr;
            wdata_d = '0;
          end
        end
      end
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT:  if (mem_done) state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_IF;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_rd    = (state_q == ARB_ISSUE) && !wr_q;
  assign mem_wr    = (state_q == ARB_ISSUE) &&  wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Completion is combinational from mem_done so the requester sees it in the same cycle.
  assign done_hit = (state_q == ARB_WAIT) && mem_done;
  assign if_done  = done_hit && (owner_q == OWN_IF);
  assign d_done   = done_hit && (owner_q == OWN_D);
  assign if_rdata = if_done ? mem_rdata : '0;
  assign d_rdata  = d_done  ? mem_rdata : '0;

`ifdef ARB_STATS_EN
  logic [15:0] conflicts_q, if_wait_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflicts_q <= '0;
      if_wait_q   <= '0;
    end else begin
      if ((state_q == ARB_IDLE) && if_req && d_req) conflicts_q <= conflicts_q + 16'd1;
      if (if_req && !if_done)                       if_wait_q   <= if_wait_q + 16'd1;
    end
  end

  assign stat_conflicts = conflicts_q;
  assign stat_if_wait   = if_wait_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: dut_a uses MAX_DATA_STREAK=4, dut_b uses 0.
// Build with ARB_STATS_EN defined to exercise the statistics counters as well.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- DUT A (streak guard 4) ----------------
  logic        if_req_a = 0, d_rd_a = 0, d_wr_a = 0;
  logic [15:0] if_addr_a = 0, d_addr_a = 0, d_wdata_a = 0;
  logic        if_done_a, d_done_a, mem_rd_a, mem_wr_a, mem_done_a;
  logic [15:0] if_rdata_a, d_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  int          lat_a = 1;
  logic [15:0] rdata_val_a = 0;
  logic        manual_a = 0, man_done_a = 0, resp_done_a = 0, pend_a = 0;
  int          cnt_a = 0;
`ifdef ARB_STATS_EN
  logic [15:0] stat_conflicts_a, stat_if_wait_a;
  logic [15:0] stat_conflicts_b, stat_if_wait_b;
`endif

  // ---------------- DUT B (strict priority) ----------------
  logic        if_req_b = 0, d_rd_b = 0, d_wr_b = 0;
  logic [15:0] if_addr_b = 0, d_addr_b = 0, d_wdata_b = 0;
  logic        if_done_b, d_done_b, mem_rd_b, mem_wr_b, mem_done_b;
  logic [15:0] if_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic        resp_done_b = 0, pend_b = 0;
  int          cnt_b = 0;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_DATA_STREAK(4)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(if_req_a), .if_addr(if_addr_a), .if_done(if_done_a), .if_rdata(if_rdata_a),
    .d_rd(d_rd_a), .d_wr(d_wr_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a),
    .d_done(d_done_a), .d_rdata(d_rdata_a),
    .mem_rd(mem_rd_a), .mem_wr(mem_wr_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_done(mem_done_a), .mem_rdata(mem_rdata_a)
`ifdef ARB_STATS_EN
    , .stat_conflicts(stat_conflicts_a), .stat_if_wait(stat_if_wait_a)
`endif
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_DATA_STREAK(0)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_done(if_done_b), .if_rdata(if_rdata_b),
    .d_rd(d_rd_b), .d_wr(d_wr_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
    .d_done(d_done_b), .d_rdata(d_rdata_b),
    .mem_rd(mem_rd_b), .mem_wr(mem_wr_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_done(mem_done_b), .mem_rdata(mem_rdata_b)
`ifdef ARB_STATS_EN
    , .stat_conflicts(stat_conflicts_b), .stat_if_wait(stat_if_wait_b)
`endif
  );

  // Memory models: mem_done arrives lat cycles after the strobe cycle.
  always begin
    @(posedge clk); #1;
    resp_done_a = 1'b0;
    if (rst) pend_a = 1'b0;
    else if (pend_a) begin
      if (cnt_a <= 1) begin resp_done_a = 1'b1; pend_a = 1'b0; end
      else cnt_a = cnt_a - 1;
    end else if (mem_rd_a || mem_wr_a) begin
      pend_a = 1'b1; cnt_a = lat_a;
    end
  end
  assign mem_done_a  = manual_a ? man_done_a : resp_done_a;
  assign mem_rdata_a = mem_done_a ? rdata_val_a : 16'h0000;

  always begin
    @(posedge clk); #1;
    resp_done_b = 1'b0;
    if (rst) pend_b = 1'b0;
    else if (pend_b) begin resp_done_b = 1'b1; pend_b = 1'b0; end
    else if (mem_rd_b || mem_wr_b) pend_b = 1'b1;
  end
  assign mem_done_b  = resp_done_b;
  assign mem_rdata_b = mem_done_b ? 16'h7777 : 16'h0000;

  // Tasks start and end at posedge+2; outputs are sampled at posedge+3.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (mem_rd_a !== 1'b0) begin n_err++; $display("FAIL reset_mem_rd got=%b exp=0", mem_rd_a); end
    n_vec++; if (mem_wr_a !== 1'b0) begin n_err++; $display("FAIL reset_mem_wr got=%b exp=0", mem_wr_a); end
    n_vec++; if (mem_addr_a !== 16'h0) begin n_err++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr_a); end
    n_vec++; if (mem_wdata_a !== 16'h0) begin n_err++; $display("FAIL reset_mem_wdata got=%h exp=0000", mem_wdata_a); end
    n_vec++; if ({if_done_a, d_done_a} !== 2'b00) begin n_err++; $display("FAIL reset_dones got=%b exp=00", {if_done_a, d_done_a}); end
    n_vec++; if ({if_rdata_a, d_rdata_a} !== 32'h0) begin n_err++; $display("FAIL reset_rdata got=%h exp=0", {if_rdata_a, d_rdata_a}); end
    @(posedge clk); #2;
  endtask

  task automatic test_single_fetch();
    int rd_cnt = 0, rd_cyc = -1, done_cnt = 0, done_cyc = -1, dd_cnt = 0;
    logic [15:0] rd_addr = 16'hxxxx, done_data = 16'hxxxx, d_rd_at_done = 16'hxxxx;
    lat_a = 2; rdata_val_a = 16'hC0DE;
    if_req_a = 1'b1; if_addr_a = 16'h0010;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (mem_rd_a) begin rd_cnt++; if (rd_cyc < 0) begin rd_cyc = i; rd_addr = mem_addr_a; end end
      if (d_done_a) dd_cnt++;
      if (if_done_a) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = i; done_data = if_rdata_a; d_rd_at_done = d_rdata_a; end
        if_req_a = 1'b0;
      end
      @(posedge clk); #2;
    end
    n_vec++; if (rd_cnt !== 1) begin n_err++; $display("FAIL fetch_rd_count got=%0d exp=1", rd_cnt); end
    n_vec++; if (rd_cyc !== 1) begin n_err++; $display("FAIL fetch_rd_cycle got=%0d exp=1", rd_cyc); end
    n_vec++; if (rd_addr !== 16'h0010) begin n_err++; $display("FAIL fetch_rd_addr got=%h exp=0010", rd_addr); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL fetch_done_count got=%0d exp=1", done_cnt); end
    n_vec++; if (done_cyc !== 3) begin n_err++; $display("FAIL fetch_done_cycle got=%0d exp=3", done_cyc); end
    n_vec++; if (done_data !== 16'hC0DE) begin n_err++; $display("FAIL fetch_rdata got=%h exp=c0de", done_data); end
    n_vec++; if (dd_cnt !== 0) begin n_err++; $display("FAIL fetch_no_d_done got=%0d exp=0", dd_cnt); end
    n_vec++; if (d_rd_at_done !== 16'h0) begin n_err++; $display("FAIL fetch_unused_d_rdata got=%h exp=0000", d_rd_at_done); end
  endtask

  task automatic test_simultaneous();
    int n_strb = 0, s0_cyc = -1, s1_cyc = -1, dd_cyc = -1, id_cyc = -1, both = 0;
    logic s0_wr = 1'bx, s1_wr = 1'bx;
    logic [15:0] s0_addr = 16'hxxxx, s0_wdata = 16'hxxxx, s1_addr = 16'hxxxx;
    logic [15:0] w_addr = 16'hxxxx, w_wdata = 16'hxxxx, f_data = 16'hxxxx;
    lat_a = 1; rdata_val_a = 16'hBEEF;
    if_req_a = 1'b1; if_addr_a = 16'h0010;
    d_wr_a = 1'b1; d_addr_a = 16'h0200; d_wdata_a = 16'h1234;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (mem_rd_a || mem_wr_a) begin
        if (n_strb == 0) begin s0_cyc = i; s0_wr = mem_wr_a; s0_addr = mem_addr_a; s0_wdata = mem_wdata_a; end
        if (n_strb == 1) begin s1_cyc = i; s1_wr = mem_wr_a; s1_addr = mem_addr_a; end
        n_strb++;
      end
      if (i == 1) begin d_addr_a = 16'hFFFF; d_wdata_a = 16'hFFFF; end
      if (i == 2) begin w_addr = mem_addr_a; w_wdata = mem_wdata_a; end
      if (if_done_a && d_done_a) both++;
      if (d_done_a && dd_cyc < 0) begin dd_cyc = i; d_wr_a = 1'b0; end
      if (if_done_a && id_cyc < 0) begin id_cyc = i; f_data = if_rdata_a; if_req_a = 1'b0; end
      @(posedge clk); #2;
    end
    n_vec++; if (s0_cyc !== 1 || s0_wr !== 1'b1) begin n_err++; $display("FAIL simul_first_wr got=cyc%0d wr%b exp=cyc1 wr1", s0_cyc, s0_wr); end
    n_vec++; if ({s0_addr, s0_wdata} !== 32'h0200_1234) begin n_err++; $display("FAIL simul_wr_addr_data got=%h/%h exp=0200/1234", s0_addr, s0_wdata); end
    n_vec++; if (dd_cyc !== 2) begin n_err++; $display("FAIL simul_d_done_cycle got=%0d exp=2", dd_cyc); end
    n_vec++; if ({w_addr, w_wdata} !== 32'h0200_1234) begin n_err++; $display("FAIL simul_latched got=%h/%h exp=0200/1234", w_addr, w_wdata); end
    n_vec++; if (s1_cyc !== 4 || s1_wr !== 1'b0) begin n_err++; $display("FAIL simul_fetch_after_bubble got=cyc%0d wr%b exp=cyc4 wr0", s1_cyc, s1_wr); end
    n_vec++; if (s1_addr !== 16'h0010) begin n_err++; $display("FAIL simul_fetch_addr got=%h exp=0010", s1_addr); end
    n_vec++; if (id_cyc !== 5 || f_data !== 16'hBEEF) begin n_err++; $display("FAIL simul_if_done got=cyc%0d %h exp=cyc5 beef", id_cyc, f_data); end
    n_vec++; if (both !== 0) begin n_err++; $display("FAIL simul_dones_exclusive got=%0d exp=0", both); end
  endtask

  task automatic test_starvation_guard();
    bit exp_if [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bit got_if [10];
    int ng = 0;
    do_reset();
    lat_a = 1;
    if_req_a = 1'b1; if_addr_a = 16'h1000;
    d_rd_a = 1'b1;   d_addr_a = 16'h2000;
    for (int i = 0; i < 80 && ng < 10; i++) begin
      #1;
      if (mem_rd_a || mem_wr_a) begin got_if[ng] = (mem_addr_a == 16'h1000); ng++; end
      @(posedge clk); #2;
    end
    if_req_a = 1'b0; d_rd_a = 1'b0;
    n_vec++; if (ng !== 10) begin n_err++; $display("FAIL streak_grant_count got=%0d exp=10", ng); end
    for (int k = 0; k < ng; k++) begin
      n_vec++;
      if (got_if[k] !== exp_if[k]) begin n_err++; $display("FAIL streak_grant_%0d got_if=%0d exp_if=%0d", k, got_if[k], exp_if[k]); end
    end
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic test_strict_priority();
    int n_if = 0, n_d = 0, fdone = -1;
    if_req_b = 1'b1; if_addr_b = 16'h1000;
    d_rd_b = 1'b1;   d_addr_b = 16'h2000;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (mem_rd_b && mem_addr_b == 16'h1000) n_if++;
      if (mem_rd_b && mem_addr_b == 16'h2000) n_d++;
      @(posedge clk); #2;
    end
    d_rd_b = 1'b0;
    for (int i = 0; i < 10 && fdone < 0; i++) begin
      #1;
      if (if_done_b) begin fdone = i; if_req_b = 1'b0; end
      @(posedge clk); #2;
    end
    if_req_b = 1'b0;
    n_vec++; if (n_if !== 0) begin n_err++; $display("FAIL strict_no_fetch got=%0d exp=0", n_if); end
    n_vec++; if (n_d < 19) begin n_err++; $display("FAIL strict_data_grants got=%0d exp>=19", n_d); end
    n_vec++; if (fdone < 0) begin n_err++; $display("FAIL strict_fetch_after_drop got=none exp=done within 10"); end
  endtask

  task automatic test_reset_in_wait();
    int rd_cyc = -1, dn_cyc = -1;
    logic [15:0] dn_data = 16'hxxxx;
    manual_a = 1'b1; man_done_a = 1'b0;
    if_req_a = 1'b1; if_addr_a = 16'h0030;
    #1; @(posedge clk); #2;
    man_done_a = 1'b1;                                     // ISSUE cycle
    #1;
    n_vec++; if (mem_rd_a !== 1'b1 || if_done_a !== 1'b0) begin n_err++; $display("FAIL rstw_issue got=rd%b done%b exp=rd1 done0", mem_rd_a, if_done_a); end
    @(posedge clk); #2;
    man_done_a = 1'b0;                                     // WAIT cycle
    #1;
    n_vec++; if (if_done_a !== 1'b0) begin n_err++; $display("FAIL rstw_wait_nodone got=%b exp=0", if_done_a); end
    rst = 1'b1; if_req_a = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0; man_done_a = 1'b1;
    #1;
    n_vec++; if ({if_done_a, d_done_a, mem_rd_a, mem_wr_a} !== 4'b0) begin n_err++; $display("FAIL rstw_after_reset got=%b exp=0000", {if_done_a, d_done_a, mem_rd_a, mem_wr_a}); end
    n_vec++; if (mem_addr_a !== 16'h0) begin n_err++; $display("FAIL rstw_addr_cleared got=%h exp=0000", mem_addr_a); end
    @(posedge clk); #2;
    #1;
    n_vec++; if ({if_done_a, d_done_a, mem_rd_a, mem_wr_a} !== 4'b0) begin n_err++; $display("FAIL rstw_idle_ignores_done got=%b exp=0000", {if_done_a, d_done_a, mem_rd_a, mem_wr_a}); end
    man_done_a = 1'b0; manual_a = 1'b0;
    @(posedge clk); #2;
    lat_a = 1; rdata_val_a = 16'h5A5A;
    if_req_a = 1'b1; if_addr_a = 16'h0040;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (mem_rd_a && rd_cyc < 0 && mem_addr_a == 16'h0040) rd_cyc = i;
      if (if_done_a && dn_cyc < 0) begin dn_cyc = i; dn_data = if_rdata_a; if_req_a = 1'b0; end
      @(posedge clk); #2;
    end
    n_vec++; if (rd_cyc !== 1) begin n_err++; $display("FAIL rstw_next_rd got=%0d exp=1", rd_cyc); end
    n_vec++; if (dn_cyc !== 2 || dn_data !== 16'h5A5A) begin n_err++; $display("FAIL rstw_next_done got=cyc%0d %h exp=cyc2 5a5a", dn_cyc, dn_data); end
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    int waits = 0;
    do_reset();
    lat_a = 1;
    for (int p = 0; p < 3; p++) begin
      bit got_d = 0, got_f = 0;
      if_req_a = 1'b1; if_addr_a = 16'h0100;
      d_rd_a = 1'b1;   d_addr_a = 16'h0300;
      for (int i = 0; i < 12 && !(got_d && got_f); i++) begin
        #1;
        if (if_req_a && !if_done_a) waits++;
        if (d_done_a) begin got_d = 1; d_rd_a = 1'b0; end
        if (if_done_a) begin got_f = 1; if_req_a = 1'b0; end
        @(posedge clk); #2;
      end
      if_req_a = 1'b0; d_rd_a = 1'b0;
      @(posedge clk); #2;
    end
    #1;
    n_vec++; if (stat_conflicts_a !== 16'd3) begin n_err++; $display("FAIL stats_conflicts got=%0d exp=3", stat_conflicts_a); end
    n_vec++; if (stat_if_wait_a !== 16'(waits) || waits != 15) begin n_err++; $display("FAIL stats_if_wait got=%0d exp=%0d (15 by hand)", stat_if_wait_a, waits); end
    @(posedge clk); #2;
  endtask
`endif

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation_guard();
    test_strict_priority();
    test_reset_in_wait();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not complete");
  end

endmodule
